delay_sink: RTL and testbench
=============================

# delay_sink

Receive-side endpoint for a fixed-latency, non-stallable `delay` pipeline. It turns that pipeline into a valid/ready stream with backpressure using a credit scheme.
- Upstream may push a word into the delay line only while `can_issue` is high.
- Words leaving the delay line land in a local FIFO of `DEPTH` entries.
- Credits return as the consumer pops.
- The block sits at the far end of any `delay` instance whose consumer can stall.

## Interface
Parameters:
- `BITS`, 1, data width.
- `DELAY`, 1, latency in cycles of the paired delay line (≥1).
- `DEPTH`, 4, FIFO entries and initial credit count (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue`  in  1  upstream pushed a word into the delay line this cycle.
- `can_issue`  out  1  at least one credit available and not flushing.
- `in_valid`  in  1  delay-line output valid (the delayed copy of `issue`).
- `in_data`  in  `BITS`  delay-line output data.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head word.
- `out_data`  out  `BITS`  head word; 0 when `out_valid` is low.

## Operation
Flush state machine, states `FLUSH` and `RUN`:
- Reset enters `FLUSH` with `flush_cnt` = `DELAY`.
- `FLUSH`: `can_issue` = 0. `in_valid` is ignored, which discards stale words still in the unreset delay line. `flush_cnt` decrements each cycle.
- `FLUSH` goes to `RUN` on the cycle `flush_cnt` reaches 0, so there are exactly `DELAY` cycles in `FLUSH`.
- `RUN` is held until the next reset.

Credits:
- `credits` is a counter of width clog2(`DEPTH`+1). Reset value is `DEPTH`.
- `issue` alone (in `RUN`, credits > 0): decrement by 1.
- Pop alone (`out_valid & out_ready`): increment by 1.
- Both in the same cycle: unchanged.
- `issue` while `can_issue` = 0 is a protocol error. Credits are not changed, so the counter never underflows.
- `can_issue` = (state == `RUN`) & (credits != 0).

FIFO:
- `DEPTH` entries, with `wr_ptr`, `rd_ptr` and `count`.
- Pointers wrap explicitly from `DEPTH`-1 to 0, so `DEPTH` need not be a power of 2.
- Push when `in_valid` in `RUN`. Pop when `out_valid & out_ready`.
- Push and pop in the same cycle while full: accepted, `count` unchanged.
- Push while full without a pop cannot occur under correct credit use. If it does, the word is dropped and the pointers and `count` are unchanged.
- Storage is not reset. `out_data` is forced to 0 when `count` = 0.

## Timing
Reset values:
- `can_issue` = 0, `out_valid` = 0, `out_data` = 0.
- `credits` = `DEPTH`, `count` = 0, pointers 0, state `FLUSH`.

Latencies:
- `in_valid` at edge N → `out_valid` high after edge N (one-cycle, registered push; output is show-ahead from the head entry).
- Pop at edge N → the credit is visible on `can_issue` after edge N.
- Round trip, issue to credit return with the consumer always ready: `DELAY` + 1 cycles.
- Full throughput (one word per cycle) requires `DEPTH` ≥ `DELAY` + 1.

Reset mid-operation:
- All state clears immediately.
- The `DELAY`-cycle flush then discards in-flight words.
- The consumer sees `out_valid` = 0 throughout.

## Configuration
`DELAY_SINK_ERR_EN`:
- Defined: adds outputs `err_overflow` (1 bit) and `err_no_credit` (1 bit).
- Both are sticky, reset to 0, and cleared only by reset.
- `err_overflow` sets on a dropped push while full.
- `err_no_credit` sets on `issue` while `can_issue` = 0.
- Undefined: the ports and flags are absent. Drops and ignored issues are silent, with identical datapath behaviour.

## Structure
- Shared package `delay_pkg`:
  - flush state enum `delay_sink_state_t` {`FLUSH`, `RUN`};
  - width helper function for the counters.
- One sub-module, `delay_sink_mem`: `DEPTH`×`BITS` register array with one write port and one asynchronous read port.
- Pointers, counters, credits and the state machine live in `delay_sink`.

## Test plan
- **Reset flush:** `DELAY`=4, pulse `in_valid` with 0xAA on cycles 1–4 after release → no push, `out_valid` = 0, `can_issue` rises on cycle 5.
- **Steady stream:** `DELAY`=4, `DEPTH`=5 (`BITS`=8, words up to 0xFF), paired with a `delay` instance, `issue` whenever `can_issue`, consumer always ready, words 0..99 → 100 words out in order, one per cycle, `can_issue` never drops.
- **Backpressure:** `DEPTH`=4, `out_ready` = 0 → exactly 4 issues accepted and `can_issue` = 0. Release `out_ready` → words drain in order and credits return to 4.
- **Simultaneous push/pop at full:** FIFO full, `in_valid` with `out_ready` → `count` stays 4, data order preserved.
- **Protocol errors (`DELAY_SINK_ERR_EN`):**
  - `issue` while `can_issue` = 0 → `err_no_credit` = 1, credits unchanged.
  - Forced `in_valid` while full, no pop → `err_overflow` = 1, word dropped.
- **Reset mid-stream:** assert `rst_n` low with 3 words buffered → `out_valid` = 0 immediately, credits = `DEPTH` after the flush, old words never appear.

Source files
------------

// File: rtl/delay_pkg.sv
// delay_pkg: shared types and width helpers for the delay line endpoints.
package delay_pkg;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } delay_sink_state_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/delay_sink_mem.sv
// delay_sink_mem: DEPTH x BITS register file, one write port,
// one asynchronous read port. Contents are not reset.
module delay_sink_mem
    import delay_pkg::*;
#(
    parameter int BITS  = 1,
    parameter int DEPTH = 4,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [BITS-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [BITS-1:0] rdata_o
);

    logic [BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/delay_sink.sv
// delay_sink: credit-based valid/ready endpoint for a fixed-latency delay line.
// Define DELAY_SINK_ERR_EN to add sticky err_overflow / err_no_credit outputs.
module delay_sink
    import delay_pkg::*;
#(
    parameter int BITS  = 1,
    parameter int DELAY = 1,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue,
    output logic            can_issue,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef DELAY_SINK_ERR_EN
    output logic [BITS-1:0] out_data,
    output logic            err_overflow,
    output logic            err_no_credit
`else
    output logic [BITS-1:0] out_data
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam int FW = cnt_width(DELAY);
    localparam int AW = ptr_width(DEPTH);

    localparam logic [CW-1:0] CRED_RST  = CW'(DEPTH);
    localparam logic [FW-1:0] FLUSH_RST = FW'(DELAY);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    delay_sink_state_t state_q, state_d;
    logic [FW-1:0]     flush_q, flush_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;

    logic            run;
    logic            pop;
    logic            take;
    logic            push;
    logic            full;
    logic            wr_en;
    logic [BITS-1:0] rd_data;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign run       = (state_q == RUN);
    assign full      = (count_q == CRED_RST);
    assign out_valid = (count_q != '0);
    assign can_issue = run & (credits_q != '0);
    assign pop       = out_valid & out_ready;
    assign take      = issue & can_issue;
    assign push      = in_valid & run;
    assign wr_en     = push & (~full | pop);
    assign out_data  = out_valid ? rd_data : '0;
    assign wr_ptr_d  = wr_en ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d  = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;

    // Stale words in the unreset delay line drain while in FLUSH.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        unique case (state_q)
            FLUSH: begin
                flush_d = flush_q - FW'(1);
                if (flush_q <= FW'(1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                flush_d = '0;
            end
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        count_d   = count_q;
        unique case ({take, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FLUSH;
            flush_q   <= FLUSH_RST;
            credits_q <= CRED_RST;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    delay_sink_mem #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

`ifdef DELAY_SINK_ERR_EN
    logic err_ov_q, err_ov_d;
    logic err_nc_q, err_nc_d;

    assign err_ov_d = err_ov_q | (push & full & ~pop);
    assign err_nc_d = err_nc_q | (issue & ~can_issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ov_q <= 1'b0;
            err_nc_q <= 1'b0;
        end else begin
            err_ov_q <= err_ov_d;
            err_nc_q <= err_nc_d;
        end
    end

    assign err_overflow  = err_ov_q;
    assign err_no_credit = err_nc_q;
`endif

endmodule

// File: tb/tb_delay_sink.sv
// tb_delay_sink: randomized bench for delay_sink against a queue-based model.
// Error-flag checks are compiled in when DELAY_SINK_ERR_EN is defined.
module tb_delay_sink;

    localparam int BITS  = 8;
    localparam int DELAY = 4;
    localparam int DEPTH = 4;
    localparam int OW    = BITS + 2;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            issue     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] in_data   = '0;
    logic            can_issue;
    logic            out_valid;
    logic [BITS-1:0] out_data;
`ifdef DELAY_SINK_ERR_EN
    logic            err_overflow;
    logic            err_no_credit;
`endif

    delay_sink #(
        .BITS  (BITS),
        .DELAY (DELAY),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue         (issue),
        .can_issue     (can_issue),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef DELAY_SINK_ERR_EN
        .out_data      (out_data),
        .err_overflow  (err_overflow),
        .err_no_credit (err_no_credit)
`else
        .out_data      (out_data)
`endif
    );

    always #5 clk = ~clk;

    logic [OW-1:0] obs;
    assign obs = {can_issue, out_valid, out_data};

    int checks = 0;
    int errors = 0;

    // Reference model: flush countdown, credit count, FIFO as a queue,
    // and the external delay line as a queue of DELAY slots.
    bit              m_run;
    int              m_flush;
    int              m_cred;
    logic [BITS-1:0] m_fifo[$];
    bit              m_eov;
    bit              m_enc;
    bit              dl_v[$];
    logic [BITS-1:0] dl_d[$];

    function automatic bit m_can();
        return m_run && (m_cred > 0);
    endfunction

    function automatic logic [OW-1:0] m_out();
        logic [BITS-1:0] h;
        h = '0;
        if (m_fifo.size() != 0) h = m_fifo[0];
        return {m_can(), m_fifo.size() != 0, h};
    endfunction

    task automatic step(input bit iss, input bit rdy, input bit inj,
                        input logic [BITS-1:0] inj_d,
                        input logic [BITS-1:0] wd);
        bit v;
        logic [BITS-1:0] d;
        bit pop;
        bit take;
        bit acc;
        v = dl_v.pop_back();
        d = dl_d.pop_back();
        if (inj) begin
            v = 1'b1;
            d = inj_d;
        end
        dl_v.push_front(iss);
        dl_d.push_front(wd);
        issue     = iss;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        pop  = rdy && (m_fifo.size() != 0);
        take = iss && m_can();
        if (iss && !take) m_enc = 1'b1;
        if (take && !pop) m_cred--;
        else if (pop && !take) m_cred++;
        acc = m_run && v && (m_fifo.size() < DEPTH || pop);
        if (m_run && v && !acc) m_eov = 1'b1;
        if (pop) m_fifo.delete(0);
        if (acc) m_fifo.push_back(d);
        if (!m_run) begin
            m_flush--;
            if (m_flush == 0) m_run = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input int hold);
        rst_n     = 1'b0;
        issue     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_run     = 1'b0;
        m_flush   = DELAY;
        m_cred    = DEPTH;
        m_fifo.delete();
        m_eov     = 1'b0;
        m_enc     = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", obs, {OW{1'b0}});
        end
`ifdef DELAY_SINK_ERR_EN
        checks++;
        if ({err_overflow, err_no_credit} !== 2'b00) begin
            errors++;
            $display("FAIL reset_errs got %b exp 00",
                     {err_overflow, err_no_credit});
        end
`endif
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_flush();
        for (int i = 0; i < DELAY + 2; i++) begin
            checks++;
            if (can_issue !== (i >= DELAY) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush cyc%0d got ci=%0b ov=%0b exp ci=%0b ov=0",
                         i + 1, can_issue, out_valid, i >= DELAY);
            end
            step(1'b0, 1'b1, i < DELAY, 8'hAA, '0);
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit iss;
        while (got < 100 && cyc < 3000) begin
            checks++;
            if (obs !== m_out()) begin
                errors++;
                $display("FAIL stream cyc%0d got %h exp %h", cyc, obs, m_out());
            end
            if (out_valid) begin
                checks++;
                if (out_data !== BITS'(got)) begin
                    errors++;
                    $display("FAIL stream_order got %h exp %h",
                             out_data, BITS'(got));
                end
                got++;
            end
            iss = m_can() && (sent < 100);
            step(iss, 1'b1, 1'b0, '0, BITS'(sent));
            if (iss) sent++;
            cyc++;
        end
        checks++;
        if (got != 100) begin
            errors++;
            $display("FAIL stream_count got %0d exp 100", got);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [BITS-1:0] w[$];
        logic [BITS-1:0] d;
        bit iss;
        for (int i = 0; i < DEPTH + DELAY + 3; i++) begin
            checks++;
            if (obs !== m_out()) begin
                errors++;
                $display("FAIL bp_fill cyc%0d got %h exp %h", i, obs, m_out());
            end
            iss = can_issue;
            d   = BITS'($urandom);
            if (iss) begin
                acc++;
                w.push_back(d);
            end
            step(iss, 1'b0, 1'b0, '0, d);
        end
        checks++;
        if (acc != DEPTH || can_issue !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepted got %0d ci=%0b exp %0d ci=0",
                     acc, can_issue, DEPTH);
        end
        for (int i = 0; i < DEPTH + 3; i++) begin
            checks++;
            if (obs !== m_out()) begin
                errors++;
                $display("FAIL bp_drain cyc%0d got %h exp %h", i, obs, m_out());
            end
            if (out_valid) begin
                checks++;
                if (w.size() == 0 || out_data !== w[0]) begin
                    errors++;
                    $display("FAIL bp_order got %h exp %h (left %0d)",
                             out_data, w.size() ? w[0] : '0, w.size());
                end
                if (w.size() != 0) w.delete(0);
            end
            step(1'b0, 1'b1, 1'b0, '0, '0);
        end
        checks++;
        if (w.size() != 0 || can_issue !== 1'b1) begin
            errors++;
            $display("FAIL bp_credits got left=%0d ci=%0b exp left=0 ci=1",
                     w.size(), can_issue);
        end
    endtask

    task automatic test_full_pushpop();
        int acc = 0;
        int n   = 0;
        logic [BITS-1:0] last;
        bit iss;
        last = '0;
        for (int i = 0; i < DEPTH + DELAY + 3; i++) begin
            checks++;
            if (obs !== m_out()) begin
                errors++;
                $display("FAIL fpp_fill cyc%0d got %h exp %h", i, obs, m_out());
            end
            iss = can_issue && (acc < DEPTH);
            if (iss) acc++;
            step(iss, 1'b0, 1'b0, '0, BITS'($urandom));
        end
        checks++;
        if (acc != DEPTH) begin
            errors++;
            $display("FAIL fpp_credits got %0d exp %0d", acc, DEPTH);
        end
        step(1'b0, 1'b1, 1'b1, 8'hE0, '0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            checks++;
            if (obs !== m_out()) begin
                errors++;
                $display("FAIL fpp_drain cyc%0d got %h exp %h", i, obs, m_out());
            end
            if (out_valid) begin
                n++;
                last = out_data;
            end
            step(1'b0, 1'b1, 1'b0, '0, '0);
        end
        checks++;
        if (n != DEPTH || last !== 8'hE0) begin
            errors++;
            $display("FAIL fpp_count got n=%0d last=%h exp n=%0d last=e0",
                     n, last, DEPTH);
        end
    endtask

    task automatic test_overflow();
        int acc = 0;
        int n   = 0;
        bit iss;
        for (int i = 0; i < DEPTH + DELAY + 3; i++) begin
            iss = can_issue && (acc < DEPTH);
            if (iss) acc++;
            step(iss, 1'b0, 1'b0, '0, BITS'(i + 1));
        end
        step(1'b0, 1'b0, 1'b1, 8'hEE, '0);
`ifdef DELAY_SINK_ERR_EN
        checks++;
        if (err_overflow !== 1'b1 || err_no_credit !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flag got ov=%0b nc=%0b exp ov=1 nc=0",
                     err_overflow, err_no_credit);
        end
`endif
        for (int i = 0; i < DEPTH + 3; i++) begin
            checks++;
            if (obs !== m_out() || (out_valid && out_data === 8'hEE)) begin
                errors++;
                $display("FAIL ovf_drain cyc%0d got %h exp %h", i, obs, m_out());
            end
            if (out_valid) n++;
            step(1'b0, 1'b1, 1'b0, '0, '0);
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL ovf_count got %0d exp %0d", n, DEPTH);
        end
    endtask

    task automatic test_reset_midstream();
        int acc = 0;
        bit iss;
        for (int i = 0; i < DELAY + 5; i++) begin
            iss = can_issue && (acc < 3);
            if (iss) acc++;
            step(iss, 1'b0, 1'b0, '0, BITS'(8'h20 + i));
        end
        step(1'b1, 1'b0, 1'b0, '0, 8'h5A);
        apply_reset(1);
        for (int i = 0; i < DELAY + 2; i++) begin
            checks++;
            if (out_valid !== 1'b0 || obs !== m_out()) begin
                errors++;
                $display("FAIL rst_flush cyc%0d got %h exp %h", i, obs, m_out());
            end
            step(1'b0, 1'b1, 1'b0, '0, '0);
        end
        acc = 0;
        for (int i = 0; i < DEPTH + DELAY + 3; i++) begin
            checks++;
            if (obs !== m_out()) begin
                errors++;
                $display("FAIL rst_refill cyc%0d got %h exp %h", i, obs, m_out());
            end
            iss = can_issue;
            if (iss) acc++;
            step(iss, 1'b0, 1'b0, '0, BITS'(8'h30 + i));
        end
        checks++;
        if (acc != DEPTH) begin
            errors++;
            $display("FAIL rst_credits got %0d exp %0d", acc, DEPTH);
        end
    endtask

    task automatic test_no_credit();
        int acc = 0;
        bit iss;
        checks++;
        if (can_issue !== 1'b0) begin
            errors++;
            $display("FAIL nc_pre got ci=%0b exp 0", can_issue);
        end
        step(1'b1, 1'b0, 1'b0, '0, 8'h99);
`ifdef DELAY_SINK_ERR_EN
        checks++;
        if (err_no_credit !== 1'b1) begin
            errors++;
            $display("FAIL nc_flag got %0b exp 1", err_no_credit);
        end
`endif
        for (int i = 0; i < DELAY + 2 + DEPTH + 2; i++) begin
            checks++;
            if (obs !== m_out() || (out_valid && out_data === 8'h99)) begin
                errors++;
                $display("FAIL nc_drain cyc%0d got %h exp %h", i, obs, m_out());
            end
            step(1'b0, i >= DELAY + 2, 1'b0, '0, '0);
        end
`ifdef DELAY_SINK_ERR_EN
        checks++;
        if (err_overflow !== m_eov) begin
            errors++;
            $display("FAIL nc_ovf got %0b exp %0b", err_overflow, m_eov);
        end
`endif
        for (int i = 0; i < DEPTH + DELAY + 3; i++) begin
            iss = can_issue;
            if (iss) acc++;
            step(iss, 1'b0, 1'b0, '0, BITS'($urandom));
        end
        checks++;
        if (acc != DEPTH) begin
            errors++;
            $display("FAIL nc_credits got %0d exp %0d", acc, DEPTH);
        end
    endtask

    task automatic test_random();
        bit iss;
        bit rdy;
        apply_reset(2);
        for (int i = 0; i < 600; i++) begin
            checks++;
            if (obs !== m_out()) begin
                errors++;
                $display("FAIL random cyc%0d got %h exp %h", i, obs, m_out());
            end
            iss = m_can() && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(iss, rdy, 1'b0, '0, BITS'($urandom));
        end
`ifdef DELAY_SINK_ERR_EN
        checks++;
        if ({err_overflow, err_no_credit} !== {m_eov, m_enc}) begin
            errors++;
            $display("FAIL random_errs got %b exp %b",
                     {err_overflow, err_no_credit}, {m_eov, m_enc});
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < DELAY; i++) begin
            dl_v.push_back(1'b0);
            dl_d.push_back('0);
        end
        @(negedge clk);
        apply_reset(2);
        test_flush();
        test_stream();
        test_backpressure();
        test_full_pushpop();
        test_overflow();
        test_reset_midstream();
        test_no_credit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
